// File: rtl/sdram_avmm_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM SDRAM controller port.
// An owner-tag FIFO steers in-order read data back to the master that issued each read.
module sdram_avmm_arbiter #(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset_n,
    input  logic [ADDR_W-1:0]              m0_address,
    input  logic                           m0_read,
    input  logic                           m0_write,
    input  logic [DATA_W-1:0]              m0_writedata,
    input  logic [DATA_W/8-1:0]            m0_byteenable,
    output logic                           m0_waitrequest,
    output logic [DATA_W-1:0]              m0_readdata,
    output logic                           m0_readdatavalid,
    input  logic [ADDR_W-1:0]              m1_address,
    input  logic                           m1_read,
    input  logic                           m1_write,
    input  logic [DATA_W-1:0]              m1_writedata,
    input  logic [DATA_W/8-1:0]            m1_byteenable,
    output logic                           m1_waitrequest,
    output logic [DATA_W-1:0]              m1_readdata,
    output logic                           m1_readdatavalid,
    output logic [ADDR_W-1:0]              s_address,
    output logic [DATA_W-1:0]              s_writedata,
    output logic [DATA_W/8-1:0]            s_byteenable,
    output logic                           s_read,
    output logic                           s_write,
    input  logic                           s_waitrequest,
    input  logic [DATA_W-1:0]              s_readdata,
    input  logic                           s_readdatavalid,
    output logic                           err_unexpected_rdv,
    output logic [1:0]                     dbg_grant,
    output logic [$clog2(MAX_PENDING):0]   dbg_count
);

    localparam int PTR_W = $clog2(MAX_PENDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_M0   = 2'd1,
        G_M1   = 2'd2
    } grant_t;

    grant_t                 grant_q, grant_d;
    logic                   last_q, last_d;
    logic [MAX_PENDING-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   err_q, err_d;

    logic req0, req1, sel_read, sel_write, stall, accept, push, pop, fifo_empty;

    // Handshake: a transfer happens in a cycle where the granted master's strobe
    // is presented on s_* and neither s_waitrequest nor the read-full stall holds it.
    always_comb begin
        sel_read     = 1'b0;
        sel_write    = 1'b0;
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        unique case (grant_q)
            G_M0: begin
                sel_read     = m0_read;
                sel_write    = m0_write;
                s_address    = m0_address;
                s_writedata  = m0_writedata;
                s_byteenable = m0_byteenable;
            end
            G_M1: begin
                sel_read     = m1_read;
                sel_write    = m1_write;
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
            end
            default: ;
        endcase
        // The raw read strobe drives the stall so the masked s_read cannot loop back.
        stall          = sel_read & (count_q == FULL);
        s_read         = sel_read & ~stall;
        s_write        = sel_write;
        accept         = (s_read | s_write) & ~s_waitrequest;
        m0_waitrequest = (grant_q == G_M0) ? (s_waitrequest | stall) : 1'b1;
        m1_waitrequest = (grant_q == G_M1) ? (s_waitrequest | stall) : 1'b1;
    end

    assign req0             = m0_read | m0_write;
    assign req1             = m1_read | m1_write;
    assign fifo_empty       = (count_q == '0);
    assign push             = accept & s_read;
    assign pop              = s_readdatavalid & ~fifo_empty;
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~tag_q[rd_ptr_q];
    assign m1_readdatavalid = pop & tag_q[rd_ptr_q];
    assign err_unexpected_rdv = err_q;
    assign dbg_grant        = grant_q;
    assign dbg_count        = count_q;

    always_comb begin
        grant_d  = grant_q;
        last_d   = last_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (s_readdatavalid & fifo_empty);
        unique case (grant_q)
            G_NONE: begin
                if (req0 && req1)  grant_d = last_q ? G_M0 : G_M1;
                else if (req0)     grant_d = G_M0;
                else if (req1)     grant_d = G_M1;
            end
            G_M0: begin
                if (accept) begin
                    last_d = 1'b0;
                    if (req1) grant_d = G_M1;
                end else if (!req0) begin
                    grant_d = req1 ? G_M1 : G_NONE;
                end
            end
            G_M1: begin
                if (accept) begin
                    last_d = 1'b1;
                    if (req0) grant_d = G_M0;
                end else if (!req1) begin
                    grant_d = req0 ? G_M0 : G_NONE;
                end
            end
            default: grant_d = G_NONE;
        endcase
        if (push) begin
            tag_d[wr_ptr_q] = (grant_q == G_M1);
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            grant_q  <= G_NONE;
            last_q   <= 1'b1;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_avmm_arbiter.sv
// Directed bench for sdram_avmm_arbiter: a per-cycle vector table for arbitration,
// read routing and full-FIFO stall, plus hand sequences for long waits, stray data and reset.
module tb_sdram_avmm_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MP = 4;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n;
    logic [AW-1:0] m0_address, m1_address, s_address;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]    m0_byteenable, m1_byteenable, s_byteenable;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic          s_read, s_write, s_waitrequest, s_readdatavalid;
    logic          err_unexpected_rdv;
    logic [1:0]    dbg_grant;
    logic [2:0]    dbg_count;

    always #5 clk_clk = ~clk_clk;

    sdram_avmm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MP)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .err_unexpected_rdv(err_unexpected_rdv),
        .dbg_grant(dbg_grant), .dbg_count(dbg_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // in_b = {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid}
    // ex_b = {s_read, s_write, m0_waitrequest, m1_waitrequest, m0_rdv, m1_rdv}
    typedef struct {
        logic [5:0] in_b;
        logic [5:0] ex_b;
        logic [1:0] g;
        logic [2:0] cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [5:0] in_b, input logic [5:0] ex_b,
                                input logic [1:0] g, input logic [2:0] cnt);
        vec_t v;
        v.in_b = in_b;
        v.ex_b = ex_b;
        v.g    = g;
        v.cnt  = cnt;
        return v;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [1:0] g);
        return (g == 2'd1) ? 24'h000010 : (g == 2'd2) ? 24'h000020 : 24'h0;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [1:0] g);
        return (g == 2'd1) ? 16'hBEEF : (g == 2'd2) ? 16'h1234 : 16'h0;
    endfunction

    function automatic logic [1:0] exp_be(input logic [1:0] g);
        return (g == 2'd1) ? 2'b11 : (g == 2'd2) ? 2'b01 : 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic w0, input logic r1, input logic w1,
                         input logic sw, input logic rdv);
        m0_read = r0; m0_write = w0; m1_read = r1; m1_write = w1;
        s_waitrequest = sw; s_readdatavalid = rdv;
        #1;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        m0_address = 24'h000010; m0_writedata = 16'hBEEF; m0_byteenable = 2'b11;
        m1_address = 24'h000020; m1_writedata = 16'h1234; m1_byteenable = 2'b01;
        s_readdata = 16'hA5C3;
        drive(0, 0, 0, 0, 0, 0);
        check("reset_ctl", {s_read, s_write, m0_waitrequest, m1_waitrequest,
                            m0_readdatavalid, m1_readdatavalid}, 6'b001100);
        check("reset_addr", s_address, 0);
        check("reset_wdata_be", {s_writedata, s_byteenable}, 0);
        check("reset_err", err_unexpected_rdv, 0);
        check("reset_grant_count", {dbg_grant, dbg_count}, 0);
        #10 reset_reset_n = 1'b1;

        // alternating reads, 3-cycle return latency, then M0 write, then M1 full-FIFO stall
        vecs[0]  = mk(6'b101000, 6'b001100, 2'd0, 3'd0);
        vecs[1]  = mk(6'b101000, 6'b100100, 2'd1, 3'd0);
        vecs[2]  = mk(6'b101000, 6'b101000, 2'd2, 3'd1);
        vecs[3]  = mk(6'b101000, 6'b100100, 2'd1, 3'd2);
        vecs[4]  = mk(6'b101001, 6'b101010, 2'd2, 3'd3);
        vecs[5]  = mk(6'b000001, 6'b000101, 2'd1, 3'd3);
        vecs[6]  = mk(6'b000001, 6'b001110, 2'd0, 3'd2);
        vecs[7]  = mk(6'b000001, 6'b001101, 2'd0, 3'd1);
        vecs[8]  = mk(6'b010000, 6'b001100, 2'd0, 3'd0);
        vecs[9]  = mk(6'b010000, 6'b010100, 2'd1, 3'd0);
        vecs[10] = mk(6'b000000, 6'b000100, 2'd1, 3'd0);
        vecs[11] = mk(6'b000000, 6'b001100, 2'd0, 3'd0);
        vecs[12] = mk(6'b001000, 6'b001100, 2'd0, 3'd0);
        vecs[13] = mk(6'b001000, 6'b101000, 2'd2, 3'd0);
        vecs[14] = mk(6'b001000, 6'b101000, 2'd2, 3'd1);
        vecs[15] = mk(6'b001000, 6'b101000, 2'd2, 3'd2);
        vecs[16] = mk(6'b001000, 6'b101000, 2'd2, 3'd3);
        vecs[17] = mk(6'b001000, 6'b001100, 2'd2, 3'd4);
        vecs[18] = mk(6'b001001, 6'b001101, 2'd2, 3'd4);
        vecs[19] = mk(6'b001000, 6'b101000, 2'd2, 3'd3);
        vecs[20] = mk(6'b000000, 6'b001000, 2'd2, 3'd4);
        vecs[21] = mk(6'b000001, 6'b001101, 2'd0, 3'd4);
        vecs[22] = mk(6'b000001, 6'b001101, 2'd0, 3'd3);
        vecs[23] = mk(6'b000001, 6'b001101, 2'd0, 3'd2);
        vecs[24] = mk(6'b000001, 6'b001101, 2'd0, 3'd1);

        for (int i = 0; i < NV; i++) begin
            tick();
            drive(vecs[i].in_b[5], vecs[i].in_b[4], vecs[i].in_b[3], vecs[i].in_b[2],
                  vecs[i].in_b[1], vecs[i].in_b[0]);
            check($sformatf("v%0d_ctl", i), {s_read, s_write, m0_waitrequest, m1_waitrequest,
                                             m0_readdatavalid, m1_readdatavalid}, vecs[i].ex_b);
            check($sformatf("v%0d_grant", i), dbg_grant, vecs[i].g);
            check($sformatf("v%0d_count", i), dbg_count, vecs[i].cnt);
            check($sformatf("v%0d_addr", i), s_address, exp_addr(vecs[i].g));
            check($sformatf("v%0d_wdata_be", i), {s_writedata, s_byteenable},
                  {exp_data(vecs[i].g), exp_be(vecs[i].g)});
        end
        check("rdata_fanout", {m0_readdata, m1_readdata}, {16'hA5C3, 16'hA5C3});

        // M1 write held off by s_waitrequest for 6 cycles while M0 also waits
        tick(); drive(0, 0, 0, 1, 1, 0);
        check("wait_none", dbg_grant, 0);
        for (int i = 0; i < 6; i++) begin
            tick(); drive(0, 1, 0, 1, 1, 0);
            check($sformatf("wait%0d_hold", i), {dbg_grant, s_address, s_write,
                                                 m0_waitrequest, m1_waitrequest},
                  {2'd2, 24'h000020, 3'b111});
        end
        tick(); drive(0, 1, 0, 1, 0, 0);
        check("wait_accept", {dbg_grant, s_write, m0_waitrequest, m1_waitrequest}, {2'd2, 3'b110});
        tick(); drive(0, 1, 0, 0, 0, 0);
        check("wait_m0_next", {dbg_grant, s_address, s_write, m0_waitrequest},
              {2'd1, 24'h000010, 2'b10});
        tick(); drive(0, 0, 0, 0, 0, 0);
        tick();
        check("wait_back_none", dbg_grant, 0);

        // stray readdatavalid with nothing outstanding
        drive(0, 0, 0, 0, 0, 1);
        check("stray_no_rdv", {m0_readdatavalid, m1_readdatavalid, err_unexpected_rdv}, 0);
        tick(); drive(0, 0, 0, 0, 0, 0);
        check("stray_err_set", err_unexpected_rdv, 1);
        repeat (5) tick();
        check("stray_err_sticky", {err_unexpected_rdv, dbg_count}, {1'b1, 3'd0});

        // three M0 reads outstanding, then asynchronous reset mid-cycle
        drive(1, 0, 0, 0, 0, 0);
        repeat (4) tick();
        check("pre_reset_count", {dbg_grant, dbg_count}, {2'd1, 3'd3});
        #2 reset_reset_n = 1'b0;
        #1;
        check("async_reset_ctl", {s_read, s_write, m0_waitrequest, m1_waitrequest,
                                  m0_readdatavalid, m1_readdatavalid}, 6'b001100);
        check("async_reset_state", {dbg_grant, dbg_count, err_unexpected_rdv, s_address}, 0);
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        reset_reset_n = 1'b1;

        tick(); drive(1, 0, 0, 0, 0, 0);
        check("post_reset_none", {dbg_grant, dbg_count}, 0);
        tick();
        check("post_reset_accept", {s_read, m0_waitrequest, dbg_grant}, {2'b10, 2'd1});
        tick(); drive(0, 0, 0, 0, 0, 1);
        check("post_reset_count1", dbg_count, 1);
        check("post_reset_route", {m0_readdatavalid, m1_readdatavalid}, 2'b10);
        tick(); drive(0, 0, 0, 0, 0, 0);
        check("post_reset_drained", {dbg_count, err_unexpected_rdv}, 0);
        drive(0, 0, 0, 0, 0, 1);
        tick(); drive(0, 0, 0, 0, 0, 0);
        check("post_reset_stray", err_unexpected_rdv, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
